// File: rtl/mc_ctrl_seq.sv
// Multi-cycle CPU control sequencer: IF/ID/EX/MEM/WB state register,
// memory handshake, per-state datapath strobes and retired-instruction count.
module mc_ctrl_seq #(
  parameter int STATE_LEN = 3,
  parameter int RET_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic [STATE_LEN-1:0] state,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 jump_en,
  output logic                 branch_en,
  output logic                 reg_write,
  output logic                 illegal_op,
  output logic                 retire,
  output logic [RET_W-1:0]     retired_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [STATE_LEN-1:0] {
    S_IF  = STATE_LEN'(0),
    S_ID  = STATE_LEN'(1),
    S_EX  = STATE_LEN'(2),
    S_MEM = STATE_LEN'(3),
    S_WB  = STATE_LEN'(4)
  } state_t;

  state_t           r_state;
  logic [5:0]       r_op;
  logic             r_ill;
  logic [RET_W-1:0] r_cnt;

  logic w_op_alu;
  logic w_op_ld;
  logic w_op_st;
  logic w_op_beq;
  logic w_op_ill;
  logic w_id_j;

  logic w_mem_req;
  logic w_mem_we;
  logic w_ir_write;
  logic w_pc_write;
  logic w_jump_en;
  logic w_branch_en;
  logic w_reg_write;
  logic w_retire;

  // Post-ID decisions use the opcode captured when leaving ID
  assign w_op_alu = (r_op == OP_R) || (r_op == OP_ADDI) ||
                    (r_op == OP_ORI);
  assign w_op_ld  = (r_op == OP_LW);
  assign w_op_st  = (r_op == OP_SW);
  assign w_op_beq = (r_op == OP_BEQ);
  assign w_op_ill = !(w_op_alu || w_op_ld || w_op_st || w_op_beq);
  assign w_id_j   = (opcode == OP_J);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IF;
      r_op    <= 6'd0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_retire) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_ID) begin
        r_op <= opcode;
      end
      unique case (r_state)
        S_IF: begin
          if (mem_ready) begin
            r_state <= S_ID;
          end
        end
        S_ID: begin
          r_state <= w_id_j ? S_IF : S_EX;
        end
        S_EX: begin
          unique case (1'b1)
            w_op_alu: r_state <= S_WB;
            w_op_ld,
            w_op_st:  r_state <= S_MEM;
            default: begin
              r_state <= S_IF;
              if (w_op_ill) begin
                r_ill <= 1'b1;
              end
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= w_op_ld ? S_WB : S_IF;
          end
        end
        S_WB: begin
          r_state <= S_IF;
        end
        default: begin
          r_state <= S_IF;
          r_ill   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_jump_en   = 1'b0;
    w_branch_en = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      S_IF: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_ID: begin
        w_jump_en = w_id_j;
        w_retire  = w_id_j;
      end
      S_EX: begin
        w_branch_en = w_op_beq;
        w_retire    = w_op_beq || w_op_ill;
      end
      S_MEM: begin
        w_mem_req = w_op_ld || w_op_st;
        w_mem_we  = w_op_st;
        w_retire  = w_op_st && mem_ready;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Strobes are forced low for as long as reset is held
  assign state       = r_state;
  assign mem_req     = rst_n & w_mem_req;
  assign mem_we      = rst_n & w_mem_we;
  assign ir_write    = rst_n & w_ir_write;
  assign pc_write    = rst_n & w_pc_write;
  assign jump_en     = rst_n & w_jump_en;
  assign branch_en   = rst_n & w_branch_en;
  assign reg_write   = rst_n & w_reg_write;
  assign retire      = rst_n & w_retire;
  assign illegal_op  = r_ill;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Bench for mc_ctrl_seq: latency table, directed sequences and random
// instruction streams checked against a per-instruction cycle model.
module tb_mc_ctrl_seq;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b0;

  logic [2:0]  state;
  logic        mem_req, mem_we, ir_write, pc_write;
  logic        jump_en, branch_en, reg_write;
  logic        illegal_op, retire;
  logic [15:0] retired_cnt;

  logic [2:0]  d4_state;
  logic        d4_mem_req, d4_mem_we, d4_ir_write, d4_pc_write;
  logic        d4_jump_en, d4_branch_en, d4_reg_write;
  logic        d4_illegal_op, d4_retire;
  logic [3:0]  c4;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  bit m_ill = 1'b0;
  int cycno = 0;

  mc_ctrl_seq #(.STATE_LEN(3), .RET_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .jump_en(jump_en),
    .branch_en(branch_en), .reg_write(reg_write),
    .illegal_op(illegal_op), .retire(retire),
    .retired_cnt(retired_cnt)
  );

  mc_ctrl_seq #(.STATE_LEN(3), .RET_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .state(d4_state), .mem_req(d4_mem_req), .mem_we(d4_mem_we),
    .ir_write(d4_ir_write), .pc_write(d4_pc_write),
    .jump_en(d4_jump_en), .branch_en(d4_branch_en),
    .reg_write(d4_reg_write), .illegal_op(d4_illegal_op),
    .retire(d4_retire), .retired_cnt(c4)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] obs();
    return {state, mem_req, mem_we, ir_write, pc_write, jump_en,
            branch_en, reg_write, retire, illegal_op, retired_cnt, c4};
  endfunction

  function automatic logic [31:0] expv(logic [2:0] st, logic [7:0] m);
    logic [31:0] c;
    c = 32'(m_cnt);
    return {st, m, m_ill, c[15:0], c[3:0]};
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  // m = {mem_req, mem_we, ir_write, pc_write, jump_en, branch_en,
  //      reg_write, retire}
  task automatic cyc(string tag, logic [5:0] op, logic rdy,
                     logic [2:0] st, logic [7:0] m);
    opcode = op;
    mem_ready = rdy;
    @(negedge clk);
    chk($sformatf("%s_cyc%0d", tag, cycno), obs(), expv(st, m));
    if (m[0]) m_cnt++;
    cycno++;
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its expected cycle sequence
  task automatic exec(string tag, logic [5:0] op, int wif, int wmem);
    bit j, alu, ld, st, beq, ill;
    j   = (op == OP_J);
    alu = (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI);
    ld  = (op == OP_LW);
    st  = (op == OP_SW);
    beq = (op == OP_BEQ);
    ill = !(j || alu || ld || st || beq);
    for (int i = 0; i < wif; i++)
      cyc(tag, r6(), 1'b0, S_IF, 8'b1000_0000);
    cyc(tag, r6(), 1'b1, S_IF, 8'b1011_0000);
    cyc(tag, op, r1(), S_ID, j ? 8'b0000_1001 : 8'h00);
    if (!j) begin
      cyc(tag, r6(), r1(), S_EX, {5'b0, beq, 1'b0, beq | ill});
      if (ill) m_ill = 1'b1;
      if (ld || st) begin
        for (int i = 0; i < wmem; i++)
          cyc(tag, r6(), 1'b0, S_MEM, {1'b1, st, 6'b0});
        cyc(tag, r6(), 1'b1, S_MEM, {1'b1, st, 5'b0, st});
      end
      if (ld || alu)
        cyc(tag, r6(), r1(), S_WB, 8'b0000_0011);
    end
  endtask

  task automatic measure(logic [5:0] op, int wif, int wmem,
                         output int lat);
    int wi = 0;
    int wm = 0;
    bit done = 1'b0;
    lat = 0;
    opcode = op;
    while (!done && lat < 60) begin
      mem_ready = 1'b1;
      if (state == S_IF && wi < wif) begin
        mem_ready = 1'b0;
        wi++;
      end
      if (state == S_MEM && wm < wmem) begin
        mem_ready = 1'b0;
        wm++;
      end
      @(negedge clk);
      done = retire;
      lat++;
      @(posedge clk);
      #1;
    end
    if (done) m_cnt++;
  endtask

  // Called 1 time unit after a rising edge
  task automatic do_reset(string tag);
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_ill = 1'b0;
    chk(tag, obs(), expv(S_IF, 8'h00));
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, obs(), expv(S_IF, 8'h00));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op;
    int         wif;
    int         wmem;
    int         lat;
    bit         ill;
  } vec_t;

  vec_t tv[9];
  logic [5:0] pool[9];

  initial begin
    int lat;
    logic [5:0] op;

    tv[0] = '{OP_R,    0, 0, 4,  1'b0};
    tv[1] = '{OP_ADDI, 1, 0, 5,  1'b0};
    tv[2] = '{OP_ORI,  0, 0, 4,  1'b0};
    tv[3] = '{OP_SW,   0, 2, 6,  1'b0};
    tv[4] = '{OP_LW,   0, 0, 5,  1'b0};
    tv[5] = '{OP_LW,   2, 3, 10, 1'b0};
    tv[6] = '{OP_BEQ,  0, 0, 3,  1'b0};
    tv[7] = '{OP_J,    3, 0, 5,  1'b0};
    tv[8] = '{OP_BAD,  0, 0, 3,  1'b1};

    pool = '{OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J,
             OP_LW, OP_BAD};

    #12;
    chk("reset_state", obs(), expv(S_IF, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tv[k]) begin
      measure(tv[k].op, tv[k].wif, tv[k].wmem, lat);
      m_ill = m_ill | tv[k].ill;
      chk($sformatf("tbl%0d_lat", k), 32'(lat), 32'(tv[k].lat));
      chk($sformatf("tbl%0d_ill", k), 32'(illegal_op), 32'(m_ill));
      chk($sformatf("tbl%0d_cnt", k), 32'(retired_cnt), 32'(m_cnt));
    end

    cyc("rstmem", r6(), 1'b1, S_IF, 8'b1011_0000);
    cyc("rstmem", OP_LW, r1(), S_ID, 8'h00);
    cyc("rstmem", r6(), r1(), S_EX, 8'h00);
    cyc("rstmem", r6(), 1'b0, S_MEM, 8'b1000_0000);
    do_reset("rst_mid_mem");

    exec("r", OP_R, 0, 0);
    exec("lw", OP_LW, 2, 3);
    exec("sw", OP_SW, 0, 0);
    exec("j", OP_J, 0, 0);
    exec("beq", OP_BEQ, 0, 0);
    exec("bad", OP_BAD, 0, 0);
    chk("seq_ill", 32'(illegal_op), 32'd1);
    chk("seq_cnt", 32'(retired_cnt), 32'd6);

    do_reset("rst_wrap");
    for (int i = 0; i < 17; i++)
      exec("jw", OP_J, 0, 0);
    chk("wrap_cnt4", 32'(c4), 32'd1);
    chk("wrap_cnt16", 32'(retired_cnt), 32'd17);

    for (int i = 0; i < 60; i++) begin
      op = pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = r6();
      exec("rnd", op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
